// File: rtl/axis_pps_gate_ctrl_pkg.sv
// Shared types for the PPS gate controller: FSM state encoding and sticky error codes.
package axis_pps_gate_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_SEND,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_RANGE   = 2'd2,
    ERR_ABORT   = 2'd3
  } err_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_ARM) || (s == ST_MEASURE) || (s == ST_SEND);
  endfunction

endpackage

// File: rtl/pps_watchdog.sv
// Missing-PPS watchdog: counts enabled cycles since the last clear and flags the cycle
// on which the count reaches the limit. A limit of zero disables it.
module pps_watchdog #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ONE;
    end
  end

  // Expiry lands exactly `limit` cycles after the clearing event when no clear intervenes.
  assign expired = enable && (limit != '0) && (count == limit - ONE);

endmodule

// File: rtl/axis_pps_gate_ctrl.sv
// Measurement sequencer: aligns to PPS on software start, accumulates N range-checked
// period samples under a missing-PPS watchdog and emits one AXIS word {N, sum}.
module axis_pps_gate_ctrl
  import axis_pps_gate_ctrl_pkg::*;
#(
  parameter int CNTR_WIDTH       = 32,
  parameter int NUM_WIDTH        = 16,
  parameter int SUM_WIDTH        = 48,
  parameter int AXIS_TDATA_WIDTH = 64
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cfg_start,
  input  logic [NUM_WIDTH-1:0]        cfg_periods,
  input  logic [CNTR_WIDTH-1:0]       cfg_min,
  input  logic [CNTR_WIDTH-1:0]       cfg_max,
  input  logic [CNTR_WIDTH-1:0]       cfg_timeout,
  input  logic [CNTR_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        sts_busy,
  output logic [1:0]                  sts_error
);

  localparam logic [NUM_WIDTH-1:0] LAST_PERIOD = NUM_WIDTH'(1);

  state_t state, state_next;

  logic                  cfg_start_q;
  logic                  start_edge;
  logic [NUM_WIDTH-1:0]  periods_q;
  logic [CNTR_WIDTH-1:0] min_q;
  logic [CNTR_WIDTH-1:0] max_q;
  logic [CNTR_WIDTH-1:0] timeout_q;
  logic [SUM_WIDTH-1:0]  sum_q;
  logic [SUM_WIDTH-1:0]  sum_new;
  logic [NUM_WIDTH-1:0]  remaining_q;

  logic                        in_range;
  logic                        wd_enable;
  logic                        wd_clear;
  logic                        wd_expired;
  logic                        start_accept;
  logic                        sample_accept;
  logic                        load_result;
  logic                        err_set;
  err_t                        err_code;
  logic [AXIS_TDATA_WIDTH-1:0] result_word;

  assign start_edge = cfg_start && !cfg_start_q;
  assign in_range   = (s_axis_tdata >= min_q) && (s_axis_tdata <= max_q);
  assign sum_new    = sum_q + SUM_WIDTH'(s_axis_tdata);
  assign sts_busy   = is_busy(state);

  // Every tvalid re-arms the watchdog, including the discarded straddling sample in ARM.
  assign wd_enable = (state == ST_ARM) || (state == ST_MEASURE);
  assign wd_clear  = start_accept || s_axis_tvalid;

  pps_watchdog #(
    .WIDTH (CNTR_WIDTH)
  ) u_watchdog (
    .clk     (aclk),
    .reset   (areset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .limit   (timeout_q),
    .expired (wd_expired)
  );

  always_comb begin
    result_word                          = '0;
    result_word[SUM_WIDTH-1:0]           = sum_new;
    result_word[SUM_WIDTH +: NUM_WIDTH]  = periods_q;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Priority inside ARM/MEASURE: abort, then sample, then watchdog expiry.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next    = state;
    start_accept  = 1'b0;
    sample_accept = 1'b0;
    load_result   = 1'b0;
    err_set       = 1'b0;
    err_code      = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (start_edge && (cfg_periods != '0)) begin
          start_accept = 1'b1;
          state_next   = ST_ARM;
        end
      end
      ST_ARM, ST_MEASURE: begin
        if (!cfg_start) begin
          err_set    = 1'b1;
          err_code   = ERR_ABORT;
          state_next = ST_IDLE;
        end else if (s_axis_tvalid) begin
          if (state == ST_ARM) begin
            state_next = ST_MEASURE;
          end else if (!in_range) begin
            err_set    = 1'b1;
            err_code   = ERR_RANGE;
            state_next = ST_ERROR;
          end else begin
            sample_accept = 1'b1;
            if (remaining_q == LAST_PERIOD) begin
              load_result = 1'b1;
              state_next  = ST_SEND;
            end
          end
        end else if (wd_expired) begin
          err_set    = 1'b1;
          err_code   = ERR_TIMEOUT;
          state_next = ST_ERROR;
        end
      end
      ST_SEND: begin
        if (m_axis_tready) begin
          state_next = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (!cfg_start) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath registers are reset as well so the output word reads zero out of reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cfg_start_q   <= 1'b0;
      periods_q     <= '0;
      min_q         <= '0;
      max_q         <= '0;
      timeout_q     <= '0;
      sum_q         <= '0;
      remaining_q   <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      sts_error     <= ERR_NONE;
    end else begin
      cfg_start_q <= cfg_start;

      if (start_accept) begin
        periods_q   <= cfg_periods;
        min_q       <= cfg_min;
        max_q       <= cfg_max;
        timeout_q   <= cfg_timeout;
        sum_q       <= '0;
        remaining_q <= cfg_periods;
        sts_error   <= ERR_NONE;
      end else if (err_set) begin
        sts_error <= err_code;
      end

      if (sample_accept) begin
        sum_q       <= sum_new;
        remaining_q <= remaining_q - LAST_PERIOD;
      end

      if (load_result) begin
        m_axis_tdata  <= result_word;
        m_axis_tvalid <= 1'b1;
      end else if ((state == ST_SEND) && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_pps_gate_ctrl.sv
// Randomized bench for axis_pps_gate_ctrl: each measurement is predicted by walking the
// sample list against the sequencer rules, then driven cycle-accurately and checked.
module tb_axis_pps_gate_ctrl;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cfg_start;
  logic [15:0] cfg_periods;
  logic [31:0] cfg_min;
  logic [31:0] cfg_max;
  logic [31:0] cfg_timeout;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        sts_busy;
  logic [1:0]  sts_error;

  int n_cmp = 0;
  int n_mis = 0;

  typedef enum {O_DONE, O_RANGE, O_TIMEOUT, O_ABORT, O_STUCK} outcome_t;

  int unsigned q_smp[$];
  int unsigned q_gap[$];

  axis_pps_gate_ctrl dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_start     (cfg_start),
    .cfg_periods   (cfg_periods),
    .cfg_min       (cfg_min),
    .cfg_max       (cfg_max),
    .cfg_timeout   (cfg_timeout),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .sts_busy      (sts_busy),
    .sts_error     (sts_error)
  );

  always #5 aclk = ~aclk;

  initial begin
    #5_000_000;
    $display("FAIL guard: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Latched configuration must be immune to later changes on the cfg_* inputs.
  task automatic scramble();
    cfg_periods = 16'($urandom);
    cfg_min     = $urandom;
    cfg_max     = $urandom;
    cfg_timeout = $urandom_range(1, 3);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      scramble();
      step();
    end
  endtask

  task automatic run_scenario(input int unsigned n, input int unsigned mn, input int unsigned mx,
                              input int unsigned to, input int abort_idx, input int stall);
    outcome_t          out;
    int                last;
    int unsigned       cnt;
    longint unsigned   sum;
    logic [63:0]       exp_word;

    out  = O_STUCK;
    last = q_smp.size() - 1;
    sum  = 0;
    cnt  = 0;
    for (int i = 0; i < q_smp.size(); i++) begin
      if (to != 0 && q_gap[i] > to) begin out = O_TIMEOUT; last = i - 1; break; end
      if (i == abort_idx) begin out = O_ABORT; last = i; break; end
      if (i == 0) continue;
      if (q_smp[i] < mn || q_smp[i] > mx) begin out = O_RANGE; last = i; break; end
      sum += q_smp[i];
      cnt++;
      if (cnt == n) begin out = O_DONE; last = i; break; end
    end
    exp_word = (64'(n) << 48) | 64'(sum);

    cfg_periods = 16'(n);
    cfg_min     = mn;
    cfg_max     = mx;
    cfg_timeout = to;
    cfg_start   = 1'b1;
    step();
    check("busy_after_start", 64'(sts_busy), 64'd1);
    check("err_cleared_on_start", 64'(sts_error), 64'd0);

    for (int i = 0; i <= last; i++) begin
      idle(int'(q_gap[i]) - 1);
      if (out == O_ABORT && i == last) cfg_start = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = q_smp[i];
      scramble();
      step();
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = $urandom;
    end

    case (out)
      O_DONE: begin
        check("send_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("send_tdata", m_axis_tdata, exp_word);
        check("send_err", 64'(sts_error), 64'd0);
        for (int k = 0; k < stall; k++) begin
          s_axis_tvalid = 1'($urandom_range(0, 1));
          s_axis_tdata  = $urandom;
          step();
          s_axis_tvalid = 1'b0;
          check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
          check("stall_tdata", m_axis_tdata, exp_word);
        end
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        check("post_hs_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("post_hs_busy", 64'(sts_busy), 64'd0);
        cfg_start = 1'b0;
        step();
        check("post_hs_err", 64'(sts_error), 64'd0);
      end
      O_RANGE: begin
        check("range_err", 64'(sts_error), 64'd2);
        check("range_busy", 64'(sts_busy), 64'd0);
        check("range_tvalid", 64'(m_axis_tvalid), 64'd0);
        cfg_start = 1'b0;
        step();
        check("range_err_sticky", 64'(sts_error), 64'd2);
      end
      O_TIMEOUT: begin
        idle(int'(to) - 1);
        check("wd_before_err", 64'(sts_error), 64'd0);
        check("wd_before_busy", 64'(sts_busy), 64'd1);
        idle(1);
        check("wd_err", 64'(sts_error), 64'd1);
        check("wd_busy", 64'(sts_busy), 64'd0);
        check("wd_tvalid", 64'(m_axis_tvalid), 64'd0);
        cfg_start = 1'b0;
        step();
      end
      O_ABORT: begin
        check("abort_err", 64'(sts_error), 64'd3);
        check("abort_busy", 64'(sts_busy), 64'd0);
        check("abort_tvalid", 64'(m_axis_tvalid), 64'd0);
        step();
      end
      default: begin
        cfg_start = 1'b0;
        step();
        check("stuck_abort_err", 64'(sts_error), 64'd3);
      end
    endcase
  endtask

  task automatic push(input int unsigned smp, input int unsigned gap);
    q_smp.push_back(smp);
    q_gap.push_back(gap);
  endtask

  initial begin
    int unsigned n, mn, mx, to, r;
    int          abort_idx;

    areset        = 1'b1;
    cfg_start     = 1'b0;
    cfg_periods   = '0;
    cfg_min       = '0;
    cfg_max       = '0;
    cfg_timeout   = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) step();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_busy", 64'(sts_busy), 64'd0);
    check("rst_err", 64'(sts_error), 64'd0);
    areset = 1'b0;
    step();

    // Basic measurement, then the same with a stalled sink.
    for (int pass = 0; pass < 2; pass++) begin
      q_smp.delete(); q_gap.delete();
      push(50, 3); push(1000, 4); push(1001, 2); push(999, 5);
      run_scenario(3, 900, 1100, 5000, -1, pass == 0 ? 0 : 10);
    end

    // Out-of-range second summed sample.
    q_smp.delete(); q_gap.delete();
    push(7, 2); push(1000, 3); push(1200, 3); push(1000, 3); push(1000, 3);
    run_scenario(4, 900, 1100, 5000, -1, 0);

    // Samples exactly at the watchdog limit are accepted.
    q_smp.delete(); q_gap.delete();
    push(5, 100); push(1000, 100); push(1000, 100); push(1000, 100);
    run_scenario(3, 900, 1100, 100, -1, 1);

    // One cycle past the limit expires.
    q_smp.delete(); q_gap.delete();
    push(5, 10); push(1000, 101); push(1000, 5); push(1000, 5);
    run_scenario(3, 900, 1100, 100, -1, 0);

    // Disabled watchdog tolerates a long gap.
    q_smp.delete(); q_gap.delete();
    push(5, 2); push(1000, 300); push(1000, 1);
    run_scenario(2, 900, 1100, 0, -1, 0);

    // Abort mid-measure, coinciding with a valid sample.
    q_smp.delete(); q_gap.delete();
    push(5, 2); push(1000, 2); push(1000, 2); push(1000, 2); push(1000, 2);
    run_scenario(4, 900, 1100, 5000, 2, 0);

    // Synchronous reset while the result is pending.
    cfg_periods = 16'd1; cfg_min = 0; cfg_max = 100; cfg_timeout = 0; cfg_start = 1'b1;
    step();
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'd9; step();
    s_axis_tdata = 32'd42; step();
    s_axis_tvalid = 1'b0;
    check("rstsend_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("rstsend_tdata", m_axis_tdata, (64'd1 << 48) | 64'd42);
    areset = 1'b1;
    step();
    check("rstsend_tvalid_after", 64'(m_axis_tvalid), 64'd0);
    check("rstsend_tdata_after", m_axis_tdata, 64'd0);
    check("rstsend_busy_after", 64'(sts_busy), 64'd0);
    areset = 1'b0; cfg_start = 1'b0;
    step();

    // N=0 start is ignored.
    cfg_periods = 16'd0; cfg_min = 0; cfg_max = 100; cfg_timeout = 5; cfg_start = 1'b1;
    step();
    check("n0_busy", 64'(sts_busy), 64'd0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'd50; step();
    s_axis_tvalid = 1'b0;
    idle(10);
    check("n0_busy_later", 64'(sts_busy), 64'd0);
    check("n0_err", 64'(sts_error), 64'd0);
    cfg_start = 1'b0;
    step();

    // Randomized measurements.
    for (int s = 0; s < 30; s++) begin
      q_smp.delete(); q_gap.delete();
      n  = $urandom_range(1, 6);
      mn = $urandom_range(100, 2000);
      mx = mn + $urandom_range(0, 200);
      to = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(4, 14);
      push($urandom, $urandom_range(1, 12));
      for (int i = 0; i < int'(n); i++) begin
        r = $urandom_range(0, 19);
        case (r)
          0:       push(mn - 1 - $urandom_range(0, 50), $urandom_range(1, 12));
          1:       push(mx + 1 + $urandom_range(0, 50), $urandom_range(1, 12));
          2:       push(mn, $urandom_range(1, 12));
          3:       push(mx, $urandom_range(1, 12));
          default: push(mn + $urandom_range(0, mx - mn), $urandom_range(1, 12));
        endcase
      end
      abort_idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n)) : -1;
      run_scenario(n, mn, mx, to, abort_idx, $urandom_range(0, 4));
    end

    // Largest N with largest samples: full-width sum, no wrap.
    q_smp.delete(); q_gap.delete();
    for (int i = 0; i < 65536; i++) push(32'hFFFF_FFFF, 1);
    run_scenario(65535, 0, 32'hFFFF_FFFF, 0, -1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
